// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state type, counter sizing helper,
// and the multiply opcode used by the downstream flag/result stage.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Opcode selecting the multiply path in the flag/result stage.
  localparam logic [3:0] ALU_OP_MUL = 4'hA;

  // Width of an iteration counter that must reach the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// Sequential unsigned shift-add multiplier (N iterations, start/busy/done).
// Optional build macro ALU_MULT_EARLY_TERM_EN: finish as soon as no multiplier
// bits remain set; results are unchanged, only latency shrinks.
module alu_seq_mult
  import alu_pkg::*;
#(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product,
  output logic             ovf
);

  localparam int CW = cnt_width(N);

  mult_state_t      state;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   mcand;
  logic [N-1:0]     mplier;
  logic [CW-1:0]    cnt;

  logic [2*N-1:0]   acc_sum;
  logic [N-1:0]     mplier_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             last;

  // Next-iteration datapath values and the RUN exit condition.
  always_comb begin
    acc_sum    = mplier[0] ? acc + mcand : acc;
    mplier_nxt = mplier >> 1;
    cnt_nxt    = cnt + CW'(1);
`ifdef ALU_MULT_EARLY_TERM_EN
    last       = (cnt_nxt == CW'(N)) || (mplier_nxt == '0);
`else
    last       = (cnt_nxt == CW'(N));
`endif
  end

  // FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          cnt    <= cnt_nxt;
          if (last) begin
            product <= acc_sum;
            ovf     <= |acc_sum[2*N-1:N];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_mult.sv
// Scoreboard bench for alu_seq_mult (N=5): stimulus pushes expected product,
// ovf and done cycle; a monitor pops and compares on every done pulse.
module tb_alu_seq_mult;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] a = '0;
  logic [4:0] b = '0;
  logic       busy;
  logic       done;
  logic [9:0] product;
  logic       ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [9:0] prod;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb[$];

  alu_seq_mult #(.N(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input int lat_full, input int lat_early);
`ifdef ALU_MULT_EARLY_TERM_EN
    return lat_early;
`else
    return lat_full;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", int'(product), int'(e.prod));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic issue(input int av, input int bv, input int prod, input int ov,
                       input int lf, input int le);
    exp_t e;
    @(negedge clk);
    a = 5'(av); b = 5'(bv); start = 1'b1;
    e.prod = 10'(prod); e.ovf = ov[0]; e.due = cyc + 1 + pick(lf, le);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_ovf", int'(ovf), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({busy, done, product, ovf}), 0);
    end

    // Basic products and boundaries
    issue(3, 7, 21, 0, 5, 3);
    drain();
    repeat (3) @(negedge clk);
    chk("held_product", int'(product), 21);
    chk("held_ovf", int'(ovf), 0);
    issue(31, 31, 961, 1, 5, 5);
    drain();
    issue(0, 31, 0, 0, 5, 5);
    drain();
    issue(3, 1, 3, 0, 5, 1);
    drain();
    issue(3, 4, 12, 0, 5, 3);
    drain();
    issue(3, 0, 0, 0, 5, 1);
    drain();

    // start during RUN is ignored, then back-to-back accept in DONE
    issue(3, 7, 21, 0, 5, 3);
    a = 5'd2; b = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("done_seen_for_b2b", int'(done), 1);
    a = 5'd2; b = 5'd2; start = 1'b1;
    e.prod = 10'd4; e.ovf = 1'b0; e.due = cyc + 1 + pick(5, 2);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_b2b", int'(busy), 1);
    drain();

    // Reset mid-RUN aborts without a done pulse
    @(negedge clk);
    a = 5'd31; b = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_outputs", int'({busy, done, product, ovf}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    issue(5, 6, 30, 0, 5, 3);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_mult.md
Name: alu_seq_mult

Overview:
- Multi-cycle unsigned shift-add multiplier sitting directly upstream of the ALU flag/result selection stage.
- Produces the 2N-bit product consumed on the multiply path.
- Produces an overflow indication equal to the OR of the product's upper N bits, so the flag stage and this block agree.
- Replaces a combinational N×N array with an N-iteration sequential datapath under a start/busy/done handshake.

Parameters:
- N, 5, operand width in bits; product width is 2N.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled on rising clk edge.
- a  in  N  multiplicand, unsigned; captured when start is accepted.
- b  in  N  multiplier, unsigned; captured when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; product and ovf valid from this cycle.
- product  out  2N  registered result a*b; held until the next accepted start.
- ovf  out  1  registered |product[2N-1:N]; aligned with product.

Behaviour:
- States: IDLE, RUN, DONE. The state register, all datapath registers and all outputs reset asynchronously on rst=1:
  - state=IDLE
  - busy=0, done=0, product=0, ovf=0
  - internal accumulator, shift registers and counter = 0
- Accept rule: start=1 on an edge while in IDLE or DONE. Then:
  - mcand(2N) = zero-extended a
  - mplier(N) = b
  - acc = 0, cnt = 0
  - state -> RUN, busy -> 1
- start while in RUN is ignored: no restart, no queueing.
- RUN, per edge:
  - if mplier[0], acc <= acc + mcand (2N-bit, cannot overflow)
  - mcand <<= 1, mplier >>= 1, cnt++
- RUN exit: on the edge where cnt reaches N (N iterations), in a single edge:
  - product <= final acc
  - ovf <= |final acc[2N-1:N]
  - done <= 1, busy <= 0
  - state -> DONE
- Latency: done rises on the Nth rising edge after the accepting edge (N=5: 5 cycles).
- DONE lasts exactly one cycle:
  - done -> 0 on the next edge
  - state -> IDLE, unless start=1 on that edge, in which case a new op is accepted (back-to-back, busy -> 1 on that same edge)
- product and ovf do not change except on the done edge or on reset. They are not cleared at accept.
- Reset mid-RUN aborts immediately: all outputs zero, no done pulse.
- Boundaries:
  - a=0 or b=0: full latency, product=0, ovf=0
  - a=b=2^N-1: product=(2^N-1)^2, no truncation

Optional Feature:
- Macro: ALU_MULT_EARLY_TERM_EN
- Defined:
  - RUN also exits on the edge where the post-shift mplier value is zero, i.e. no remaining set multiplier bits.
  - Iterations = max(1, index of highest set bit of b + 1).
  - b=0 gives 1 iteration.
  - done timing and the DONE state otherwise identical.
- Undefined: fixed N iterations for every operand. Results are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg holds:
  - the state typedef (IDLE/RUN/DONE enum, 2-bit)
  - a localparam counter-width function or constant, $clog2(N+1)
- The same package is usable by the flag stage for the multiply opcode constant.
- No sub-module: the datapath (accumulator, two shifters, counter) and FSM fit in a single module.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> busy=0, done=0, product=0, ovf=0; unchanged for 10 idle cycles.
- a=3, b=7, start 1 cycle -> busy=1 for 5 cycles, done pulses on the 5th edge, product=21 (0x015), ovf=0; product held afterwards.
- a=31, b=31 -> product=961 (0x3C1), ovf=1 (upper bits = 30); a=0, b=31 -> product=0, ovf=0, still 5-cycle latency.
- start re-asserted during RUN (a=2, b=2 mid-op of 3*7) -> ignored; result 21 at the original done time. Then start held high in the DONE cycle with a=2, b=2 -> accepted back-to-back, next done gives 4.
- rst asserted on the 3rd RUN cycle of 31*31 -> outputs 0 immediately, no done pulse; subsequent 5*6 gives 30, ovf=0.
- With ALU_MULT_EARLY_TERM_EN:
  - 3*1 -> done 1 cycle after accept, product=3
  - 3*4 -> done after 3 cycles, product=12
  - 3*0 -> done after 1 cycle, product=0
  - Without the macro, the same cases all take 5 cycles.
